// File: rtl/multiplexor_pkg.sv
// Shared defaults and the data word type for the round-robin TDM multiplexer.
package multiplexor_pkg;
    localparam int ANCHO_DEF   = 8;
    localparam int CANALES_DEF = 8;
    localparam int SELW_DEF    = $clog2(CANALES_DEF);

    typedef logic [ANCHO_DEF-1:0] palabra_t;
endpackage

// File: rtl/multiplexor_tdm_canal_retencion.sv
// One channel's holding register with its pending and sticky overwrite flags.
module canal_retencion
    import multiplexor_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             reloj,
    input  logic             reinicio_n,
    input  logic             v,
    input  logic [ANCHO-1:0] e,
    input  logic             emitir,
    input  logic             limpiar,
    output logic [ANCHO-1:0] retenido,
    output logic             pend,
    output logic             desb
);
    logic [ANCHO-1:0] hold_q, hold_d;
    logic             pend_q, pend_d;
    logic             desb_q, desb_d;
    logic             sobrescribe;

    // A write landing on the edge that emits this channel is a refill, not an overwrite.
    always_comb begin
        sobrescribe = v && pend_q && !emitir;
        hold_d      = v ? e : hold_q;
        pend_d      = v || (pend_q && !emitir);
        desb_d      = sobrescribe || (desb_q && !limpiar);
    end

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            hold_q <= '0;
            pend_q <= 1'b0;
            desb_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            pend_q <= pend_d;
            desb_q <= desb_d;
        end
    end

    assign retenido = hold_q;
    assign pend     = pend_q;
    assign desb     = desb_q;
endmodule

// File: rtl/multiplexor_tdm.sv
// Round-robin TDM multiplexer: buffers one word per channel and emits one channel slot per enabled cycle.
module multiplexor_tdm
    import multiplexor_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int CANALES = CANALES_DEF,
    parameter int SELW    = SELW_DEF
) (
    input  logic                     reloj,
    input  logic                     reinicio_n,
    input  logic [CANALES*ANCHO-1:0] e,
    input  logic [CANALES-1:0]       v,
    input  logic                     habilitar,
    input  logic                     limpiar_desb,
    output logic [ANCHO-1:0]         dato_sal,
    output logic [SELW-1:0]          canal_sal,
    output logic                     valido_sal,
    output logic                     inicio_trama,
    output logic [CANALES-1:0]       pendiente,
    output logic [CANALES-1:0]       desborde
);
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [ANCHO-1:0] dato_q, dato_d;
    logic [SELW-1:0]  canal_q, canal_d;
    logic             valido_q, valido_d;
    logic             inicio_q, inicio_d;

    logic [ANCHO-1:0]   retenido [CANALES];
    logic [CANALES-1:0] emitir;

    for (genvar k = 0; k < CANALES; k++) begin : g_canal
        assign emitir[k] = habilitar && (ptr_q == SELW'(k)) && pendiente[k];

        canal_retencion #(
            .ANCHO(ANCHO)
        ) u_canal (
            .reloj     (reloj),
            .reinicio_n(reinicio_n),
            .v         (v[k]),
            .e         (e[k*ANCHO +: ANCHO]),
            .emitir    (emitir[k]),
            .limpiar   (limpiar_desb),
            .retenido  (retenido[k]),
            .pend      (pendiente[k]),
            .desb      (desborde[k])
        );
    end

    // The pointer visits every channel in turn; empty slots still consume a cycle.
    always_comb begin
        ptr_d    = ptr_q;
        dato_d   = dato_q;
        canal_d  = canal_q;
        valido_d = valido_q;
        inicio_d = inicio_q;
        if (habilitar) begin
            ptr_d    = ptr_q + 1'b1;
            canal_d  = ptr_q;
            valido_d = pendiente[ptr_q];
            dato_d   = pendiente[ptr_q] ? retenido[ptr_q] : '0;
            inicio_d = (ptr_q == '0);
        end
    end

    always_ff @(posedge reloj or negedge reinicio_n) begin
        if (!reinicio_n) begin
            ptr_q    <= '0;
            dato_q   <= '0;
            canal_q  <= '0;
            valido_q <= 1'b0;
            inicio_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            dato_q   <= dato_d;
            canal_q  <= canal_d;
            valido_q <= valido_d;
            inicio_q <= inicio_d;
        end
    end

    assign dato_sal     = dato_q;
    assign canal_sal    = canal_q;
    assign valido_sal   = valido_q;
    assign inicio_trama = inicio_q;
endmodule

// File: tb/tb_multiplexor_tdm.sv
// Directed bench for multiplexor_tdm with a queue of expected emitted words.
module tb_multiplexor_tdm;
    import multiplexor_pkg::*;

    localparam int ANCHO   = ANCHO_DEF;
    localparam int CANALES = CANALES_DEF;
    localparam int SELW    = SELW_DEF;

    typedef struct packed {
        logic [SELW-1:0] canal;
        palabra_t        dato;
    } esperado_t;

    logic                     reloj;
    logic                     reinicio_n;
    logic [CANALES*ANCHO-1:0] e;
    logic [CANALES-1:0]       v;
    logic                     habilitar;
    logic                     limpiar_desb;
    logic [ANCHO-1:0]         dato_sal;
    logic [SELW-1:0]          canal_sal;
    logic                     valido_sal;
    logic                     inicio_trama;
    logic [CANALES-1:0]       pendiente;
    logic [CANALES-1:0]       desborde;

    esperado_t sb[$];
    int        n_chk  = 0;
    int        n_fail = 0;

    multiplexor_tdm #(
        .ANCHO  (ANCHO),
        .CANALES(CANALES),
        .SELW   (SELW)
    ) dut (
        .reloj       (reloj),
        .reinicio_n  (reinicio_n),
        .e           (e),
        .v           (v),
        .habilitar   (habilitar),
        .limpiar_desb(limpiar_desb),
        .dato_sal    (dato_sal),
        .canal_sal   (canal_sal),
        .valido_sal  (valido_sal),
        .inicio_trama(inicio_trama),
        .pendiente   (pendiente),
        .desborde    (desborde)
    );

    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic      hab;
        esperado_t x;
        hab = habilitar;
        @(posedge reloj);
        #1;
        if (hab && valido_sal === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_word", {29'd0, canal_sal}, 32'hFFFF_FFFF);
            end else begin
                x = sb.pop_front();
                chk("sb_canal", 32'(canal_sal), 32'(x.canal));
                chk("sb_dato", 32'(dato_sal), 32'(x.dato));
            end
        end
    endtask

    task automatic put(input int k, input logic [ANCHO-1:0] val);
        e[k*ANCHO +: ANCHO] = val;
        v[k] = 1'b1;
    endtask

    task automatic espera(input int k, input logic [ANCHO-1:0] val);
        esperado_t x;
        x.canal = SELW'(k);
        x.dato  = val;
        sb.push_back(x);
    endtask

    task automatic clr();
        v            = '0;
        limpiar_desb = 1'b0;
    endtask

    // Advance until the next visited channel is tgt.
    task automatic align(input int tgt);
        logic [SELW-1:0] prev;
        int              n;
        prev = SELW'(tgt + CANALES - 1);
        n    = 0;
        while (canal_sal !== prev && n < 2*CANALES) begin
            tick();
            n++;
        end
        if (canal_sal !== prev) chk("align_timeout", 32'(canal_sal), 32'(prev));
    endtask

    initial begin
        reinicio_n   = 1'b0;
        habilitar    = 1'b0;
        limpiar_desb = 1'b0;
        e            = '0;
        v            = '0;

        // Reset state
        repeat (2) tick();
        chk("rst_dato", 32'(dato_sal), 32'h0);
        chk("rst_canal", 32'(canal_sal), 32'h0);
        chk("rst_valido", 32'(valido_sal), 32'h0);
        chk("rst_inicio", 32'(inicio_trama), 32'h0);
        chk("rst_pend", 32'(pendiente), 32'h0);
        chk("rst_desb", 32'(desborde), 32'h0);
        reinicio_n = 1'b1;
        habilitar  = 1'b1;
        tick();
        chk("first_canal", 32'(canal_sal), 32'h0);
        chk("first_inicio", 32'(inicio_trama), 32'h1);
        chk("first_valido", 32'(valido_sal), 32'h0);

        // Single word on channel 5 captured while channel 0 is visited
        align(0);
        put(5, 8'hA5);
        espera(5, 8'hA5);
        tick();
        clr();
        chk("single_pend_set", 32'(pendiente[5]), 32'h1);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("single_valido", 32'(valido_sal), 32'(i == 5));
        end
        chk("single_pend_clr", 32'(pendiente[5]), 32'h0);

        // All channels loaded as channel 7 is visited
        align(7);
        for (int k = 0; k < CANALES; k++) begin
            put(k, ANCHO'(8'h10 + k));
            espera(k, ANCHO'(8'h10 + k));
        end
        tick();
        clr();
        chk("all_pend", 32'(pendiente), 32'hFF);
        for (int k = 0; k < CANALES; k++) begin
            tick();
            chk("all_valido", 32'(valido_sal), 32'h1);
            chk("all_inicio", 32'(inicio_trama), 32'(k == 0));
        end
        chk("all_pend_clr", 32'(pendiente), 32'h0);

        // Overflow on channel 3, then clear racing a new overflow on channel 6
        align(0);
        put(3, 8'h11);
        tick();
        clr();
        put(3, 8'h22);
        espera(3, 8'h22);
        tick();
        clr();
        chk("ovf_desb_set", 32'(desborde), 32'h08);
        tick();
        tick();
        chk("ovf_desb_sticky", 32'(desborde[3]), 32'h1);
        put(6, 8'h55);
        tick();
        clr();
        put(6, 8'h66);
        espera(6, 8'h66);
        limpiar_desb = 1'b1;
        tick();
        clr();
        chk("ovf_set_wins", 32'(desborde), 32'h40);
        tick();
        limpiar_desb = 1'b1;
        tick();
        clr();
        chk("ovf_cleared", 32'(desborde), 32'h0);

        // Collision: refill channel 2 on the edge that emits its old word
        align(0);
        put(2, 8'h44);
        espera(2, 8'h44);
        tick();
        clr();
        tick();
        put(2, 8'h33);
        espera(2, 8'h33);
        tick();
        clr();
        chk("col_valido", 32'(valido_sal), 32'h1);
        chk("col_pend", 32'(pendiente[2]), 32'h1);
        chk("col_desb", 32'(desborde), 32'h0);
        for (int i = 1; i <= CANALES; i++) begin
            tick();
            chk("col_delay", 32'(valido_sal), 32'(i == CANALES));
        end

        // Freeze with writes on channel 1
        habilitar = 1'b0;
        for (int i = 0; i < 5; i++) begin
            put(1, ANCHO'(8'h70 + i));
            tick();
            clr();
            chk("frz_dato", 32'(dato_sal), 32'h33);
            chk("frz_canal", 32'(canal_sal), 32'h2);
            chk("frz_valido", 32'(valido_sal), 32'h1);
            chk("frz_inicio", 32'(inicio_trama), 32'h0);
        end
        espera(1, 8'h74);
        chk("frz_pend", 32'(pendiente[1]), 32'h1);
        chk("frz_desb", 32'(desborde[1]), 32'h1);
        habilitar = 1'b1;
        tick();
        chk("frz_resume_canal", 32'(canal_sal), 32'h3);
        chk("frz_resume_valido", 32'(valido_sal), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("frz_emit", 32'(valido_sal), 32'(i == 6));
        end
        limpiar_desb = 1'b1;
        tick();
        clr();

        // Asynchronous reset mid-frame discards buffered words
        put(4, 8'h99);
        tick();
        clr();
        #2;
        reinicio_n = 1'b0;
        #1;
        chk("arst_dato", 32'(dato_sal), 32'h0);
        chk("arst_canal", 32'(canal_sal), 32'h0);
        chk("arst_valido", 32'(valido_sal), 32'h0);
        chk("arst_pend", 32'(pendiente), 32'h0);
        chk("arst_desb", 32'(desborde), 32'h0);
        sb.delete();
        tick();
        reinicio_n = 1'b1;
        tick();
        chk("arst_first_canal", 32'(canal_sal), 32'h0);
        chk("arst_first_inicio", 32'(inicio_trama), 32'h1);
        for (int i = 0; i < CANALES; i++) begin
            tick();
            chk("arst_discarded", 32'(valido_sal), 32'h0);
        end

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
